// File: rtl/tx_img_fifo.sv
// -----------------------------------------------------------------------------
// tx_img_fifo
//
// Programmable-depth synchronous image FIFO on the TX path. It buffers pixel
// words from the image processor toward the UART TX serializer. Storage is a
// flat array of MAX_DEPTH words. The active depth and the cell width are
// reloaded from the register block whenever the FIFO is idle and empty, and
// also at a flush. Both sides use valid/ready handshakes. The read side is
// first-word-fall-through.
//
// Optional build macro: TX_IMG_FIFO_STATS_EN adds a max_count high-watermark
// output.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_depth             requested active depth (0 or >MAX_DEPTH -> MAX_DEPTH)
//   cfg_cell_width        requested data bits per entry (0 or >DATA_WIDTH -> full)
//   cfg_almost_empty_lvl  almost_empty asserts while count <= this level
//   cfg_almost_full_lvl   almost_full asserts while free slots <= this level
//   flush                 synchronous clear of contents (sticky flags kept)
//   clr_sticky            clears overflow/underflow (and max_count)
//   wr_valid/wr_ready/wr_data   producer handshake
//   rd_valid/rd_ready/rd_data   consumer handshake, rd_data is the head word
//   count                 occupied entries
//   empty/full/almost_empty/almost_full   status
//   overflow/underflow    sticky error flags
//   max_count             (TX_IMG_FIFO_STATS_EN only) high-watermark of count
// -----------------------------------------------------------------------------
module tx_img_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DEPTH  = 1024,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_W-1:0]      cfg_depth,
  input  logic [5:0]            cfg_cell_width,
  input  logic [10:0]           cfg_almost_empty_lvl,
  input  logic [10:0]           cfg_almost_full_lvl,
  input  logic                  flush,
  input  logic                  clr_sticky,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
`ifdef TX_IMG_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]      max_count
`endif
);

  localparam int PTR_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DEPTH);
  localparam logic [6:0]       DW7   = 7'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [MAX_DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      eff_depth;
  logic [6:0]            eff_width;
  logic [CNT_W-1:0]      cfg_depth_sel;
  logic [6:0]            cfg_width_sel;
  logic [DATA_WIDTH-1:0] width_mask;
  logic                  push;
  logic                  pop;
  logic                  cfg_load;

  // Advance a pointer, wrapping at the active depth. Arbitrary depths
  // (non-power-of-two) are supported, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] d);
    if ({{(CNT_W-PTR_W){1'b0}}, p} == d - CNT_W'(1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Sanitise the requested configuration. Out-of-range values fall back to
  // the physical limits.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cfg_depth_sel = cfg_depth;
    if (cfg_depth == '0 || cfg_depth > MAX_D) cfg_depth_sel = MAX_D;
    cfg_width_sel = {1'b0, cfg_cell_width};
    if (cfg_cell_width == '0 || {1'b0, cfg_cell_width} > DW7) cfg_width_sel = DW7;
  end

  // Bits at or above the active cell width are stored as zero.
  always_comb begin
    width_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) width_mask[i] = (7'(i) < eff_width);
  end

  assign full         = (count == eff_depth);
  assign empty        = (count == '0);
  assign wr_ready     = !full;
  assign rd_valid     = !empty;
  assign push         = wr_valid && wr_ready;
  assign pop          = rd_valid && rd_ready;
  assign rd_data      = empty ? '0 : mem[rd_ptr];
  assign almost_empty = (count <= {{(CNT_W-11){1'b0}}, cfg_almost_empty_lvl});
  assign almost_full  = ((eff_depth - count) <= {{(CNT_W-11){1'b0}}, cfg_almost_full_lvl});

  // The configuration only changes while nothing is stored, so pointer wrap
  // and masking stay consistent for the words already in the array.
  assign cfg_load = flush || (empty && !push);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      eff_depth <= MAX_D;
      eff_width <= DW7;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr, eff_depth);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr, eff_depth);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      if (cfg_load) begin
        eff_depth <= cfg_depth_sel;
        eff_width <= cfg_width_sel;
      end
    end
  end

  // NOTE: the storage array has no reset. Empty entries are never visible
  // because rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data & width_mask;
  end

  // Sticky error flags. A set condition in the same cycle beats clr_sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_valid && full) overflow <= 1'b1;
      else if (clr_sticky)  overflow <= 1'b0;
      if (rd_ready && empty) underflow <= 1'b1;
      else if (clr_sticky)   underflow <= 1'b0;
    end
  end

`ifdef TX_IMG_FIFO_STATS_EN
  // High-watermark of count. On clr_sticky it restarts from the current
  // count, so a non-zero occupancy in that cycle is kept. Flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 max_count <= '0;
    else if (clr_sticky)        max_count <= count;
    else if (count > max_count) max_count <= count;
  end
`endif

endmodule
